// File: rtl/ar_m_arb_if.sv
// ---------------------------------------------------------------------------
// ar_m_arb_if : bundle between the ar_m_arb arbiter, its 8 requesters, the
//               shared ar_m registered mux and the consumer of the read data.
//
// Signals
//   req[7:0]       requester -> arbiter   per-requester read request
//   ack            consumer  -> arbiter   accepts dout while dout_vld=1
//   a, b, c        arbiter   -> ar_m      mux select, a = MSB, c = LSB
//   q_in[W-1:0]    ar_m      -> arbiter   mux data output
//   gnt[7:0]       arbiter   -> requester one-hot grant, held per transaction
//   dout[W-1:0]    arbiter   -> consumer  captured mux data
//   dout_vld       arbiter   -> consumer  dout valid, held until ack
//   busy           arbiter   -> anyone    high outside IDLE
//   dbg_state[1:0] arbiter   -> debug     FSM state (0 IDLE, 1 SETTLE, 2 DONE)
//
// Handshake: dout is transferred on a rising clk edge where dout_vld=1 and
// ack=1. Once dout_vld rises, dout stays stable until that edge; ack sampled
// while dout_vld=0 has no effect.
//
// Modports
//   slave  : the arbiter side (drives select, grant, data and status)
//   master : the environment side (requesters, mux and consumer)
// ---------------------------------------------------------------------------
interface ar_m_arb_if #(
  parameter int WIDTH = 8
);
  logic [7:0]       req;
  logic             ack;
  logic             a;
  logic             b;
  logic             c;
  logic [WIDTH-1:0] q_in;
  logic [7:0]       gnt;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic             busy;
  logic [1:0]       dbg_state;

  modport slave (
    input  req,
    input  ack,
    input  q_in,
    output a,
    output b,
    output c,
    output gnt,
    output dout,
    output dout_vld,
    output busy,
    output dbg_state
  );

  modport master (
    output req,
    output ack,
    output q_in,
    input  a,
    input  b,
    input  c,
    input  gnt,
    input  dout,
    input  dout_vld,
    input  busy,
    input  dbg_state
  );
endinterface

// File: rtl/ar_m_arb.sv
// ---------------------------------------------------------------------------
// ar_m_arb : round-robin arbiter/sequencer sharing one 8-entry registered
//            array mux (ar_m) among 8 requesters.
//
// A request found in IDLE is granted to the first set req bit at or above the
// round-robin pointer (wrapping 7 -> 0). The mux select {a,b,c} is driven to
// the winner's index on the grant edge and then left untouched until the
// transaction ends, so the mux never sees a select glitch. After waiting
// MUX_LAT edges for the mux pipeline, q_in is captured into dout and offered
// with dout_vld; the transaction ends on the edge where ack is seen, and only
// then does the pointer move past the winner.
//
// Parameters
//   WIDTH    data width of q_in / dout (must match the interface WIDTH)
//   MUX_LAT  clk edges from a select change to valid q at the mux output,
//            legal 0..7 (0 = combinational mux)
//
// Ports
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset; aborts any transaction silently
//   bus    ar_m_arb_if.slave: req, ack, q_in in; a, b, c, gnt, dout,
//          dout_vld, busy, dbg_state out (all outputs registered)
//
// Timing (MUX_LAT = L)
//   req sampled at edge E0 -> {a,b,c}, gnt, busy valid after E0
//                          -> dout, dout_vld valid after E0+L+1
//   ack sampled at edge Ea -> gnt=0, dout_vld=0, busy=0 after Ea
//   back-to-back repeat period with ack held high: L+3 cycles
// ---------------------------------------------------------------------------
module ar_m_arb #(
  parameter int WIDTH   = 8,
  parameter int MUX_LAT = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  ar_m_arb_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Settle counter load value; a 3-bit counter covers the full 0..7 range.
  localparam logic [2:0] LAT_INIT = 3'(MUX_LAT);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [2:0]       ptr_q,   ptr_d;    // round-robin search start
  logic [2:0]       sel_q,   sel_d;    // current winner == mux select
  logic [2:0]       cnt_q,   cnt_d;    // remaining settle edges
  logic [7:0]       gnt_q,   gnt_d;
  logic [WIDTH-1:0] dout_q,  dout_d;
  logic             vld_q,   vld_d;
  logic             busy_q,  busy_d;

  // -------------------------------------------------------------------------
  // Round-robin winner search
  // -------------------------------------------------------------------------
  // Scanning offsets from 7 down to 0 lets the last hit (the smallest offset
  // from ptr) win, which gives the "first set bit upward from ptr" rule
  // without needing an early loop exit. The 3-bit addition wraps 7 -> 0.
  logic [2:0] win_idx;
  logic       win_any;

  always_comb begin
    win_idx = ptr_q;
    for (int k = 7; k >= 0; k--) begin
      if (bus.req[ptr_q + 3'(k)]) begin
        win_idx = ptr_q + 3'(k);
      end
    end
  end

  assign win_any = |bus.req;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    dout_d  = dout_q;
    vld_d   = vld_q;
    busy_d  = busy_q;

    unique case (state_q)
      S_IDLE: begin
        // req is looked at only here; a/b/c keep their last value while idle.
        if (win_any) begin
          sel_d   = win_idx;
          gnt_d   = 8'd1 << win_idx;
          cnt_d   = LAT_INIT;
          busy_d  = 1'b1;
          state_d = S_SETTLE;
        end
      end

      S_SETTLE: begin
        // The select changed on the grant edge; each decrement is one more
        // edge the mux has seen it. At zero the mux output is current.
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          dout_d  = bus.q_in;
          vld_d   = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        // Everything visible is frozen until the consumer takes the data.
        // dout itself is left holding the last captured word.
        if (bus.ack) begin
          vld_d   = 1'b0;
          gnt_d   = 8'd0;
          busy_d  = 1'b0;
          ptr_d   = sel_q + 3'd1;
          state_d = S_IDLE;
        end
      end

      default: begin
        // Unused encoding: fall back to a quiet IDLE.
        gnt_d   = 8'd0;
        vld_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers (FSM state and all outputs)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= 3'd0;
      sel_q   <= 3'd0;
      cnt_q   <= 3'd0;
      gnt_q   <= 8'd0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.a         = sel_q[2];
  assign bus.b         = sel_q[1];
  assign bus.c         = sel_q[0];
  assign bus.gnt       = gnt_q;
  assign bus.dout      = dout_q;
  assign bus.dout_vld  = vld_q;
  assign bus.busy      = busy_q;
  assign bus.dbg_state = state_q;

  // -------------------------------------------------------------------------
  // Invariants
  // -------------------------------------------------------------------------
  // At most one requester is ever granted.
  a_gnt_onehot : assert property (
    @(posedge clk) disable iff (!rst_n) $onehot0(gnt_q)
  );

  // Once a transaction is under way the mux select does not move.
  a_sel_stable : assert property (
    @(posedge clk) disable iff (!rst_n) (state_q != S_IDLE) |=> $stable(sel_q)
  );

  // dout_vld is exactly the DONE state.
  a_vld_done : assert property (
    @(posedge clk) disable iff (!rst_n) vld_q == (state_q == S_DONE)
  );

endmodule
